// File: rtl/spi_flash_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// spi_flash_arbiter_pkg
//   Shared types for the SPI flash arbiter: FSM state encoding and the
//   owner identifier used for tie-break fairness.
// ----------------------------------------------------------------------------
package spi_flash_arbiter_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWN_DSP = 2'd1,
        ARB_OWN_CPU = 2'd2,
        ARB_GUARD   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_DSP = 1'b0,
        OWNER_CPU = 1'b1
    } owner_e;

endpackage

// File: rtl/spi_flash_arbiter_cs_sync.sv
// ----------------------------------------------------------------------------
// spi_flash_arbiter_cs_sync
//   Multi-flop synchronizer for an active-low chip select that is
//   asynchronous to sysclk. Clears to 1 (deasserted) on reset so a reset
//   can never be mistaken for a request.
// Ports
//   sysclk     in  system clock
//   reset_INV  in  asynchronous active-low reset
//   cs_INV_i   in  raw chip select, active low
//   cs_INV_o   out synchronized chip select, active low
// ----------------------------------------------------------------------------
module spi_flash_arbiter_cs_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic cs_INV_i,
    output logic cs_INV_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value; blocking would collapse the chain into one flop.
            sync_q <= {sync_q[SYNC_STAGES-2:0], cs_INV_i};
        end
    end

    assign cs_INV_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// ----------------------------------------------------------------------------
// spi_flash_arbiter
//   Shares one SPI flash between the DSP SPI master and the CPU SPI0 master.
//   Ownership is granted on (synchronized) chip-select assertion, held until
//   release, and followed by a guard gap before the flash can change hands.
//   The SPI datapath is purely combinational, steered by the registered state.
// Ports
//   sysclk, reset_INV         clock / asynchronous active-low reset
//   dsp_en, cpu_en            bank enables; 0 masks or revokes that master
//   dsp_cs_INV/clk/mosi       DSP SPI in;  dsp_miso flash data back to DSP
//   cpu_cs_INV/clk/mosi       CPU SPI in;  cpu_miso flash data back to CPU
//   flash_cs_INV/clk/mosi     to the flash; flash_miso from the flash
//   dsp_grant, cpu_grant      registered ownership indicators
//   timeout_err               sticky: watchdog revoked a grant
// ----------------------------------------------------------------------------
module spi_flash_arbiter
    import spi_flash_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int GUARD_CYCLES  = 4,
    parameter int TIMEOUT_WIDTH = 24,
    parameter bit TIMEOUT_EN    = 1'b1
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic dsp_en,
    input  logic cpu_en,
    input  logic dsp_cs_INV,
    input  logic dsp_clk,
    input  logic dsp_mosi,
    output logic dsp_miso,
    input  logic cpu_cs_INV,
    input  logic cpu_clk,
    input  logic cpu_mosi,
    output logic cpu_miso,
    output logic flash_cs_INV,
    output logic flash_clk,
    output logic flash_mosi,
    input  logic flash_miso,
    output logic dsp_grant,
    output logic cpu_grant,
    output logic timeout_err
);

    // Guard counter runs 0 .. GUARD_CYCLES-1.
    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GUARD_W-1:0]       GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_MAX   = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST  = WDOG_MAX - 1'b1;

    arb_state_e               state_q, state_d;
    owner_e                   last_owner_q, last_owner_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic [GUARD_W-1:0]       guard_q, guard_d;
    logic                     timeout_err_q, timeout_err_d;

    logic dsp_cs_sync, cpu_cs_sync;
    logic req_dsp, req_cpu;
    logic wdog_expire;

    spi_flash_arbiter_cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dsp_cs_sync (
        .sysclk    (sysclk),
        .reset_INV (reset_INV),
        .cs_INV_i  (dsp_cs_INV),
        .cs_INV_o  (dsp_cs_sync)
    );

    spi_flash_arbiter_cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cpu_cs_sync (
        .sysclk    (sysclk),
        .reset_INV (reset_INV),
        .cs_INV_i  (cpu_cs_INV),
        .cs_INV_o  (cpu_cs_sync)
    );

    // Enables are quasi-static and used unsynchronized; dropping one removes
    // the request on the next edge, which revokes an active grant.
    assign req_dsp = ~dsp_cs_sync & dsp_en;
    assign req_cpu = ~cpu_cs_sync & cpu_en;

    // Expire on the edge where the owner count would reach all-ones, so the
    // grant lasts exactly 2^TIMEOUT_WIDTH-1 cycles.
    assign wdog_expire = TIMEOUT_EN && (wdog_q == WDOG_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state_q       <= ARB_IDLE;
            last_owner_q  <= OWNER_CPU;   // DSP wins the first tie
            wdog_q        <= '0;
            guard_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            wdog_q        <= wdog_d;
            guard_q       <= guard_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        guard_d       = guard_q;

        unique case (state_q)
            ARB_IDLE: begin
                // On a tie the master not granted last wins; this also keeps a
                // master that held CS through the guard from starving the other.
                if (req_dsp && (!req_cpu || last_owner_q == OWNER_CPU)) begin
                    state_d      = ARB_OWN_DSP;
                    last_owner_d = OWNER_DSP;
                end else if (req_cpu) begin
                    state_d      = ARB_OWN_CPU;
                    last_owner_d = OWNER_CPU;
                end
            end
            ARB_OWN_DSP: begin
                if (!req_dsp) begin
                    state_d = ARB_GUARD;
                end else if (wdog_expire) begin
                    state_d       = ARB_GUARD;
                    timeout_err_d = 1'b1;
                end
            end
            ARB_OWN_CPU: begin
                if (!req_cpu) begin
                    state_d = ARB_GUARD;
                end else if (wdog_expire) begin
                    state_d       = ARB_GUARD;
                    timeout_err_d = 1'b1;
                end
            end
            ARB_GUARD: begin
                if (guard_q == GUARD_LAST) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Both counters restart on every state change.
        if (state_d != state_q) begin
            wdog_d  = '0;
            guard_d = '0;
        end else begin
            if ((state_q == ARB_OWN_DSP || state_q == ARB_OWN_CPU) && wdog_q != WDOG_MAX) begin
                wdog_d = wdog_q + 1'b1;
            end
            if (state_q == ARB_GUARD) begin
                guard_d = guard_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode and SPI steering
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path can hold an old value and infer a latch.
        flash_cs_INV = 1'b1;
        flash_clk    = 1'b0;
        flash_mosi   = 1'b0;
        dsp_miso     = 1'b0;
        cpu_miso     = 1'b0;
        dsp_grant    = 1'b0;
        cpu_grant    = 1'b0;

        unique case (state_q)
            ARB_OWN_DSP: begin
                dsp_grant    = 1'b1;
                flash_cs_INV = dsp_cs_INV;
                flash_clk    = dsp_clk;
                flash_mosi   = dsp_mosi;
                dsp_miso     = flash_miso;
            end
            ARB_OWN_CPU: begin
                cpu_grant    = 1'b1;
                flash_cs_INV = cpu_cs_INV;
                flash_clk    = cpu_clk;
                flash_mosi   = cpu_mosi;
                cpu_miso     = flash_miso;
            end
            default: ;
        endcase
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_arbiter
//   Self-checking bench for spi_flash_arbiter. Expected timing comes from the
//   arbiter's rules (sync latency, guard gap, watchdog length) and expected
//   routing from the current owner, tracked here at transaction level.
// ----------------------------------------------------------------------------
module tb_spi_flash_arbiter;

    localparam int SYNC     = 2;
    localparam int GUARD    = 4;
    localparam int TW       = 8;
    localparam int LAT      = SYNC + 1;        // CS edge -> grant edge
    localparam int GAP      = GUARD + 1;       // guard cycles plus the IDLE decision cycle
    localparam int WDOG_LEN = (1 << TW) - 1;   // cycles a stuck grant survives

    typedef enum {M_NONE, M_DSP, M_CPU} owner_t;

    logic sysclk, reset_INV;
    logic dsp_en, cpu_en;
    logic dsp_cs_INV, dsp_clk, dsp_mosi, dsp_miso;
    logic cpu_cs_INV, cpu_clk, cpu_mosi, cpu_miso;
    logic flash_cs_INV, flash_clk, flash_mosi, flash_miso;
    logic dsp_grant, cpu_grant, timeout_err;

    int     n_checks = 0;
    int     n_fail   = 0;
    owner_t last_owner_m;

    spi_flash_arbiter #(
        .SYNC_STAGES   (SYNC),
        .GUARD_CYCLES  (GUARD),
        .TIMEOUT_WIDTH (TW),
        .TIMEOUT_EN    (1'b1)
    ) dut (
        .sysclk       (sysclk),
        .reset_INV    (reset_INV),
        .dsp_en       (dsp_en),
        .cpu_en       (cpu_en),
        .dsp_cs_INV   (dsp_cs_INV),
        .dsp_clk      (dsp_clk),
        .dsp_mosi     (dsp_mosi),
        .dsp_miso     (dsp_miso),
        .cpu_cs_INV   (cpu_cs_INV),
        .cpu_clk      (cpu_clk),
        .cpu_mosi     (cpu_mosi),
        .cpu_miso     (cpu_miso),
        .flash_cs_INV (flash_cs_INV),
        .flash_clk    (flash_clk),
        .flash_mosi   (flash_mosi),
        .flash_miso   (flash_miso),
        .dsp_grant    (dsp_grant),
        .cpu_grant    (cpu_grant),
        .timeout_err  (timeout_err)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- reference model helpers ----------------
    function automatic owner_t other(input owner_t w);
        return (w == M_DSP) ? M_CPU : M_DSP;
    endfunction

    function automatic logic [1:0] exp_gcode(input owner_t w);
        case (w)
            M_DSP:   return 2'b10;
            M_CPU:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // {flash_cs_INV, flash_clk, flash_mosi, dsp_miso, cpu_miso} for a given owner
    function automatic logic [4:0] exp_bus(input owner_t w);
        case (w)
            M_DSP:   return {dsp_cs_INV, dsp_clk, dsp_mosi, flash_miso, 1'b0};
            M_CPU:   return {cpu_cs_INV, cpu_clk, cpu_mosi, 1'b0, flash_miso};
            default: return 5'b10000;
        endcase
    endfunction

    function automatic logic [4:0] obs_bus();
        return {flash_cs_INV, flash_clk, flash_mosi, dsp_miso, cpu_miso};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic set_cs(input owner_t w, input logic v);
        if (w == M_DSP) dsp_cs_INV = v;
        else            cpu_cs_INV = v;
    endtask

    task automatic drive_random();
        dsp_clk    = 1'($urandom);
        dsp_mosi   = 1'($urandom);
        cpu_clk    = 1'($urandom);
        cpu_mosi   = 1'($urandom);
        flash_miso = 1'($urandom);
    endtask

    // Negedges until the grant of 'who' equals 'level'; -1 if the bound expires.
    task automatic wait_grant(input owner_t who, input logic level, input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge sysclk);
            if (((who == M_DSP) ? dsp_grant : cpu_grant) === level) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        dsp_cs_INV = 1'b1;
        cpu_cs_INV = 1'b1;
        reset_INV  = 1'b0;
        tick(1);
        reset_INV  = 1'b1;
        last_owner_m = M_CPU;
        tick(1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_INV  = 1'b0;
        dsp_en     = 1'b1;
        cpu_en     = 1'b1;
        dsp_cs_INV = 1'b1;
        cpu_cs_INV = 1'b1;
        dsp_clk    = 1'b1;
        dsp_mosi   = 1'b1;
        cpu_clk    = 1'b1;
        cpu_mosi   = 1'b1;
        flash_miso = 1'b1;
        tick(2);
        n_checks++;
        if (obs_bus() !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_bus: got %b expected %b", obs_bus(), 5'b10000);
        end
        n_checks++;
        if ({dsp_grant, cpu_grant, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", {dsp_grant, cpu_grant, timeout_err}, 3'b000);
        end
        reset_INV = 1'b1;
        last_owner_m = M_CPU;
        tick(4);
        n_checks++;
        if ({obs_bus(), dsp_grant, cpu_grant} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", {obs_bus(), dsp_grant, cpu_grant}, 7'b1000000);
        end
    endtask

    task automatic test_dsp_transfer();
        int         c;
        logic [7:0] pattern;
        @(negedge sysclk);
        dsp_cs_INV = 1'b0;
        wait_grant(M_DSP, 1'b1, LAT + 5, c);
        n_checks++;
        if (c !== LAT) begin
            n_fail++;
            $display("FAIL dsp_grant_latency: got %0d expected %0d", c, LAT);
        end
        last_owner_m = M_DSP;
        n_checks++;
        if (cpu_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL dsp_only_cpu_grant: got %b expected 0", cpu_grant);
        end
        for (int byte_i = 0; byte_i < 2; byte_i++) begin
            pattern = 8'($urandom);
            for (int k = 7; k >= 0; k--) begin
                @(negedge sysclk);
                drive_random();
                dsp_clk  = 1'b0;
                dsp_mosi = pattern[k];
                #1;
                n_checks++;
                if (obs_bus() !== exp_bus(M_DSP)) begin
                    n_fail++;
                    $display("FAIL dsp_route_lo: got %b expected %b", obs_bus(), exp_bus(M_DSP));
                end
                dsp_clk = 1'b1;
                #1;
                n_checks++;
                if (obs_bus() !== exp_bus(M_DSP)) begin
                    n_fail++;
                    $display("FAIL dsp_route_hi: got %b expected %b", obs_bus(), exp_bus(M_DSP));
                end
            end
        end
        @(negedge sysclk);
        dsp_cs_INV = 1'b1;
        dsp_clk    = 1'b0;
        wait_grant(M_DSP, 1'b0, LAT + 5, c);
        n_checks++;
        if (c !== LAT) begin
            n_fail++;
            $display("FAIL dsp_release_latency: got %0d expected %0d", c, LAT);
        end
        n_checks++;
        if (obs_bus() !== 5'b10000) begin
            n_fail++;
            $display("FAIL dsp_release_bus: got %b expected %b", obs_bus(), 5'b10000);
        end
        tick(GAP + 2);
    endtask

    task automatic test_tie();
        int         c;
        owner_t     exp_w;
        logic [1:0] g;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            exp_w = other(last_owner_m);
            @(negedge sysclk);
            dsp_cs_INV = 1'b0;
            cpu_cs_INV = 1'b0;
            c = -1;
            g = 2'b00;
            for (int i = 1; i <= LAT + 5; i++) begin
                @(negedge sysclk);
                if (dsp_grant === 1'b1 || cpu_grant === 1'b1) begin
                    c = i;
                    g = {dsp_grant, cpu_grant};
                    break;
                end
            end
            n_checks++;
            if (g !== exp_gcode(exp_w)) begin
                n_fail++;
                $display("FAIL tie_winner round %0d: got %b expected %b", r, g, exp_gcode(exp_w));
            end
            n_checks++;
            if (c !== LAT) begin
                n_fail++;
                $display("FAIL tie_latency round %0d: got %0d expected %0d", r, c, LAT);
            end
            last_owner_m = exp_w;
            tick($urandom_range(3, 12));
            @(negedge sysclk);
            if (r == 0) begin
                // Winner leaves while the loser keeps CS low: loser takes over after the guard.
                set_cs(exp_w, 1'b1);
                wait_grant(exp_w, 1'b0, LAT + 5, c);
                n_checks++;
                if (obs_bus() !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL guard_bus_idle: got %b expected %b", obs_bus(), 5'b10000);
                end
                wait_grant(other(exp_w), 1'b1, GAP + 5, c);
                n_checks++;
                if (c !== GAP) begin
                    n_fail++;
                    $display("FAIL handover_gap: got %0d expected %0d", c, GAP);
                end
                last_owner_m = other(exp_w);
                @(negedge sysclk);
                set_cs(other(exp_w), 1'b1);
                wait_grant(other(exp_w), 1'b0, LAT + 5, c);
            end else begin
                dsp_cs_INV = 1'b1;
                cpu_cs_INV = 1'b1;
                wait_grant(exp_w, 1'b0, LAT + 5, c);
            end
            tick(GAP + 2);
        end
    endtask

    task automatic test_no_preempt();
        int c;
        int n;
        @(negedge sysclk);
        cpu_cs_INV = 1'b0;
        wait_grant(M_CPU, 1'b1, LAT + 5, c);
        n_checks++;
        if (c !== LAT) begin
            n_fail++;
            $display("FAIL cpu_grant_latency: got %0d expected %0d", c, LAT);
        end
        last_owner_m = M_CPU;
        @(negedge sysclk);
        dsp_cs_INV = 1'b0;
        n = $urandom_range(10, 30);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            drive_random();
            #1;
            n_checks++;
            if ({dsp_grant, cpu_grant} !== 2'b01) begin
                n_fail++;
                $display("FAIL no_preempt_grant: got %b expected %b", {dsp_grant, cpu_grant}, 2'b01);
            end
            n_checks++;
            if (obs_bus() !== exp_bus(M_CPU)) begin
                n_fail++;
                $display("FAIL no_preempt_route: got %b expected %b", obs_bus(), exp_bus(M_CPU));
            end
        end
        @(negedge sysclk);
        cpu_cs_INV = 1'b1;
        wait_grant(M_CPU, 1'b0, LAT + 5, c);
        wait_grant(M_DSP, 1'b1, GAP + 5, c);
        n_checks++;
        if (c !== GAP) begin
            n_fail++;
            $display("FAIL waiting_dsp_gap: got %0d expected %0d", c, GAP);
        end
        last_owner_m = M_DSP;
        @(negedge sysclk);
        dsp_cs_INV = 1'b1;
        wait_grant(M_DSP, 1'b0, LAT + 5, c);
        tick(GAP + 2);
    endtask

    task automatic test_en_revoke();
        int c;
        @(negedge sysclk);
        dsp_cs_INV = 1'b0;
        wait_grant(M_DSP, 1'b1, LAT + 5, c);
        last_owner_m = M_DSP;
        tick(3);
        dsp_en = 1'b0;
        #1;
        n_checks++;
        if ({dsp_grant, flash_cs_INV} !== 2'b10) begin
            n_fail++;
            $display("FAIL revoke_before_edge: got %b expected %b", {dsp_grant, flash_cs_INV}, 2'b10);
        end
        @(negedge sysclk);
        n_checks++;
        if ({dsp_grant, flash_cs_INV} !== 2'b01) begin
            n_fail++;
            $display("FAIL revoke_next_edge: got %b expected %b", {dsp_grant, flash_cs_INV}, 2'b01);
        end
        tick(GAP + 3);
        n_checks++;
        if ({obs_bus(), dsp_grant, cpu_grant} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL revoke_stays_idle: got %b expected %b", {obs_bus(), dsp_grant, cpu_grant}, 7'b1000000);
        end
        dsp_cs_INV = 1'b1;
        tick(LAT + 1);
        dsp_en = 1'b1;
        tick(2);
    endtask

    task automatic test_mask();
        int c;
        @(negedge sysclk);
        cpu_en     = 1'b0;
        cpu_cs_INV = 1'b0;
        wait_grant(M_CPU, 1'b1, LAT + GAP + 4, c);
        n_checks++;
        if (c !== -1) begin
            n_fail++;
            $display("FAIL masked_cpu_granted: got %0d expected -1", c);
        end
        cpu_cs_INV = 1'b1;
        tick(LAT + 1);
        cpu_en = 1'b1;
        tick(2);
    endtask

    task automatic test_watchdog();
        int c;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before_watchdog: got %b expected 0", timeout_err);
        end
        @(negedge sysclk);
        cpu_cs_INV = 1'b0;
        wait_grant(M_CPU, 1'b1, LAT + 5, c);
        last_owner_m = M_CPU;
        wait_grant(M_CPU, 1'b0, WDOG_LEN + 50, c);
        n_checks++;
        if (c !== WDOG_LEN) begin
            n_fail++;
            $display("FAIL watchdog_hold: got %0d expected %0d", c, WDOG_LEN);
        end
        n_checks++;
        if ({flash_cs_INV, timeout_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL watchdog_revoke: got %b expected %b", {flash_cs_INV, timeout_err}, 2'b11);
        end
        // CS still low and nobody else asking: the stuck master is granted again.
        wait_grant(M_CPU, 1'b1, GAP + 5, c);
        n_checks++;
        if (c !== GAP) begin
            n_fail++;
            $display("FAIL watchdog_regrant: got %0d expected %0d", c, GAP);
        end
        @(negedge sysclk);
        cpu_cs_INV = 1'b1;
        wait_grant(M_CPU, 1'b0, LAT + 5, c);
        tick(GAP + 2);
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", timeout_err);
        end
        do_reset();
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared_by_reset: got %b expected 0", timeout_err);
        end
    endtask

    task automatic test_async_reset();
        int c;
        @(negedge sysclk);
        cpu_cs_INV = 1'b0;
        wait_grant(M_CPU, 1'b1, LAT + 5, c);
        @(negedge sysclk);
        cpu_clk  = 1'b1;
        cpu_mosi = 1'b1;
        #2;
        reset_INV = 1'b0;
        #1;
        n_checks++;
        if ({obs_bus(), dsp_grant, cpu_grant} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL async_reset_idle: got %b expected %b", {obs_bus(), dsp_grant, cpu_grant}, 7'b1000000);
        end
        cpu_cs_INV = 1'b1;
        @(negedge sysclk);
        reset_INV = 1'b1;
        last_owner_m = M_CPU;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_dsp_transfer();
        test_tie();
        test_no_preempt();
        test_en_revoke();
        test_mask();
        test_watchdog();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
